// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment encoder and capture blocks:
// segment bit order, the pattern for each displayable symbol, and the
// 4-bit codes those symbols map to.
package sevenseg_pkg;

  // Segment bit order inside a pattern: bit0=a ... bit6=g, 1 = lit.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int SEG_W  = 7;
  localparam int CODE_W = 4;

  // Patterns written g..a, MSB first.
  localparam logic [SEG_W-1:0] SEG_0       = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1       = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2       = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3       = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4       = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5       = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6       = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7       = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8       = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9       = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_CORRECT = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_ERROR   = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_OFF     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_QUERY   = 7'b1001011;

  localparam logic [CODE_W-1:0] CODE_CORRECT = 4'd10;
  localparam logic [CODE_W-1:0] CODE_ERROR   = 4'd11;
  localparam logic [CODE_W-1:0] CODE_OFF     = 4'd12;
  localparam logic [CODE_W-1:0] CODE_QUERY   = 4'd13;
  localparam logic [CODE_W-1:0] CODE_INVALID = 4'd15;

  // Capture state: nothing accepted yet, or holding an accepted pattern.
  typedef enum logic {
    EMPTY  = 1'b0,
    LOCKED = 1'b1
  } cap_state_t;

endpackage

// File: rtl/sevenseg_capture_if.sv
// Sample/result bundle between a segment source and the capture block.
interface sevenseg_capture_if
  import sevenseg_pkg::*;
#(
  parameter int ERR_W = 8
);
  logic              en;
  logic [SEG_W-1:0]  seg;
  logic              clr_err;
  logic [CODE_W-1:0] value;
  logic              valid;
  logic              invalid;
  logic              changed;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output en, seg, clr_err,
    input  value, valid, invalid, changed, err_count
  );

  modport slave (
    input  en, seg, clr_err,
    output value, valid, invalid, changed, err_count
  );
endinterface

// File: rtl/sevenseg_pattern_decode.sv
// Combinational segment-pattern to display-code decoder. Any pattern not
// in the symbol table decodes to CODE_INVALID with invalid_o set.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0]  pattern_i,
  output logic [CODE_W-1:0] code_o,
  output logic              invalid_o
);

  // Exact-match lookup of every known symbol.
  always_comb begin
    code_o = CODE_INVALID;
    case (pattern_i)
      SEG_0:       code_o = 4'd0;
      SEG_1:       code_o = 4'd1;
      SEG_2:       code_o = 4'd2;
      SEG_3:       code_o = 4'd3;
      SEG_4:       code_o = 4'd4;
      SEG_5:       code_o = 4'd5;
      SEG_6:       code_o = 4'd6;
      SEG_7:       code_o = 4'd7;
      SEG_8:       code_o = 4'd8;
      SEG_9:       code_o = 4'd9;
      SEG_CORRECT: code_o = CODE_CORRECT;
      SEG_ERROR:   code_o = CODE_ERROR;
      SEG_OFF:     code_o = CODE_OFF;
      SEG_QUERY:   code_o = CODE_QUERY;
      default:     code_o = CODE_INVALID;
    endcase
  end

  assign invalid_o = (code_o == CODE_INVALID);

endmodule

// File: rtl/sevenseg_capture.sv
// Receive side of the 7-segment link: registers the incoming pattern,
// requires it to hold for STABLE_CYCLES enabled samples before accepting
// it, decodes the accepted pattern and counts undecodable accepts.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
)(
  input  logic               clk,
  input  logic               rst,
  sevenseg_capture_if.slave  bus
);

  // 8 bits covers the full legal STABLE_CYCLES range of 1..255.
  localparam int                CNT_W      = 8;
  localparam logic [CNT_W-1:0]  STABLE_CNT = CNT_W'(STABLE_CYCLES);

  logic [SEG_W-1:0]  seg_q;
  logic [SEG_W-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEG_W-1:0]  acc_q;
  cap_state_t        state_q;
  logic [CODE_W-1:0] value_q;
  logic              valid_q;
  logic              invalid_q;
  logic              changed_q;
  logic [ERR_W-1:0]  err_q;

  logic [CODE_W-1:0] dec_code;
  logic              dec_invalid;
  logic              accept;

  // The pattern being judged is seg_q, which becomes the candidate this edge.
  sevenseg_pattern_decode u_decode (
    .pattern_i (seg_q),
    .code_o    (dec_code),
    .invalid_o (dec_invalid)
  );

  // Stability counter next state and accept decision.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (seg_q == cand_q) begin
      if (cnt_q < STABLE_CNT) cnt_d = cnt_q + 1'b1;
    end else begin
      cand_d = seg_q;
      cnt_d  = CNT_W'(1);
    end
    accept = bus.en && (cnt_d == STABLE_CNT) &&
             ((state_q == EMPTY) || (seg_q != acc_q));
  end

  // Input sample and candidate tracking; frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q  <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (bus.en) begin
      seg_q  <= bus.seg;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  // Accept FSM with registered outputs; changed drops every edge unless re-armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      acc_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      case (state_q)
        EMPTY, LOCKED: begin
          if (accept) begin
            acc_q     <= seg_q;
            value_q   <= dec_code;
            invalid_q <= dec_invalid;
            valid_q   <= 1'b1;
            changed_q <= 1'b1;
            state_q   <= LOCKED;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Saturating invalid-accept counter; clear beats increment and ignores en.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (bus.clr_err) begin
      err_q <= '0;
    end else if (accept && dec_invalid && !(&err_q)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign bus.value     = value_q;
  assign bus.valid     = valid_q;
  assign bus.invalid   = invalid_q;
  assign bus.changed   = changed_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: two instances (8-bit and 2-bit error counter)
// share one stimulus stream; accepted results are queued at drive time and
// popped when the DUT pulses changed.
module tb_sevenseg_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] seg;
  logic       clr_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int value;
    int inv;
    int e8;
    int e2;
  } exp_t;

  exp_t sb[$];
  int   e8 = 0;
  int   e2 = 0;
  bit   prev_chg = 1'b0;

  sevenseg_capture_if #(.ERR_W(8)) ifa ();
  sevenseg_capture_if #(.ERR_W(2)) ifb ();

  assign ifa.en = en;  assign ifa.seg = seg;  assign ifa.clr_err = clr_err;
  assign ifb.en = en;  assign ifb.seg = seg;  assign ifb.clr_err = clr_err;

  sevenseg_capture #(.STABLE_CYCLES(4), .ERR_W(8)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  sevenseg_capture #(.STABLE_CYCLES(4), .ERR_W(2)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_code(input logic [6:0] p);
    case (p)
      7'b0111111: return 0;
      7'b0000110: return 1;
      7'b1011011: return 2;
      7'b1001111: return 3;
      7'b1100110: return 4;
      7'b1101101: return 5;
      7'b1111101: return 6;
      7'b0000111: return 7;
      7'b1111111: return 8;
      7'b1101111: return 9;
      7'b0111001: return 10;
      7'b1111001: return 11;
      7'b0000000: return 12;
      7'b1001011: return 13;
      default:    return 15;
    endcase
  endfunction

  // Queue the result expected when pattern p is next accepted.
  task automatic push_accept(input logic [6:0] p, input bit clr);
    exp_t e;
    e.value = ref_code(p);
    e.inv   = (e.value == 15) ? 1 : 0;
    if (clr) begin
      e8 = 0;
      e2 = 0;
    end else if (e.inv == 1) begin
      if (e8 < 255) e8++;
      if (e2 < 3)   e2++;
    end
    e.e8 = e8;
    e.e2 = e2;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every changed pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_chg = 1'b0;
    end else begin
      if (ifa.changed) begin
        chk("chg_one_cycle", int'(prev_chg), 0);
        chk("chg_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_value",   int'(ifa.value),     e.value);
          chk("sb_invalid", int'(ifa.invalid),   e.inv);
          chk("sb_valid",   int'(ifa.valid),     1);
          chk("sb_err8",    int'(ifa.err_count), e.e8);
          chk("sb_err2",    int'(ifb.err_count), e.e2);
          chk("sb_chg_b",   int'(ifb.changed),   1);
        end
      end
      prev_chg = ifa.changed;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; clr_err = 1'b0; seg = 7'b0000000;
    tick(2);
    chk("rst_value",   int'(ifa.value),     0);
    chk("rst_valid",   int'(ifa.valid),     0);
    chk("rst_invalid", int'(ifa.invalid),   0);
    chk("rst_changed", int'(ifa.changed),   0);
    chk("rst_err8",    int'(ifa.err_count), 0);
    chk("rst_err2",    int'(ifb.err_count), 0);
    rst = 1'b0;

    // Clean capture of "2": driven after edge 1, visible at edge 6.
    tick(1);
    seg = 7'b1011011;
    push_accept(seg, 1'b0);
    tick(4);
    chk("cap_valid_e5", int'(ifa.valid), 0);
    tick(1);
    chk("cap_value_e6",   int'(ifa.value),   2);
    chk("cap_valid_e6",   int'(ifa.valid),   1);
    chk("cap_invalid_e6", int'(ifa.invalid), 0);
    chk("cap_changed_e6", int'(ifa.changed), 1);
    tick(1);
    chk("cap_changed_e7", int'(ifa.changed), 0);

    // Glitch of "3" for two samples, then back to "2".
    seg = 7'b1001111;
    tick(2);
    seg = 7'b1011011;
    tick(8);
    chk("glitch_value",   int'(ifa.value),     2);
    chk("glitch_changed", int'(ifa.changed),   0);
    chk("glitch_err",     int'(ifa.err_count), 0);

    // Invalid accepts, then a clear colliding with the third increment.
    seg = 7'b1010101;
    push_accept(seg, 1'b0);
    tick(6);
    chk("inv1_value",   int'(ifa.value),     15);
    chk("inv1_invalid", int'(ifa.invalid),   1);
    chk("inv1_err",     int'(ifa.err_count), 1);
    seg = 7'b0110000;
    push_accept(seg, 1'b0);
    tick(6);
    chk("inv2_err", int'(ifa.err_count), 2);
    seg = 7'b1110000;
    push_accept(seg, 1'b1);
    tick(4);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err8",    int'(ifa.err_count), 0);
    chk("clr_err2",    int'(ifb.err_count), 0);
    chk("clr_changed", int'(ifa.changed),   1);
    tick(1);

    // Enable freeze mid-settle of "C".
    seg = 7'b0111001;
    push_accept(seg, 1'b0);
    tick(2);
    en = 1'b0;
    tick(10);
    chk("frz_value",   int'(ifa.value),   15);
    chk("frz_changed", int'(ifa.changed), 0);
    en = 1'b1;
    tick(2);
    chk("frz_value_e2", int'(ifa.value), 15);
    tick(1);
    chk("frz_value_e3",   int'(ifa.value),   10);
    chk("frz_changed_e3", int'(ifa.changed), 1);
    chk("frz_invalid_e3", int'(ifa.invalid), 0);
    en = 1'b0;
    tick(1);
    chk("frz_chg_clear", int'(ifa.changed), 0);
    chk("frz_hold",      int'(ifa.value),   10);
    en = 1'b1;

    // Saturation of the 2-bit counter with four-sample invalid patterns.
    seg = 7'b1010101; push_accept(seg, 1'b0); tick(4);
    seg = 7'b0110000; push_accept(seg, 1'b0); tick(4);
    seg = 7'b1110000; push_accept(seg, 1'b0); tick(4);
    seg = 7'b0101010; push_accept(seg, 1'b0); tick(4);
    seg = 7'b1000001; push_accept(seg, 1'b0); tick(6);
    chk("sat_err2", int'(ifb.err_count), 3);
    chk("sat_err8", int'(ifa.err_count), 5);
    tick(3);
    chk("sat_err2_hold", int'(ifb.err_count), 3);

    // Reset in the middle of settling on "8".
    seg = 7'b1111111;
    tick(3);
    rst = 1'b1;
    seg = 7'b0000000;
    tick(1);
    chk("mrst_value",   int'(ifa.value),     0);
    chk("mrst_valid",   int'(ifa.valid),     0);
    chk("mrst_invalid", int'(ifa.invalid),   0);
    chk("mrst_changed", int'(ifa.changed),   0);
    chk("mrst_err8",    int'(ifa.err_count), 0);
    chk("mrst_err2",    int'(ifb.err_count), 0);
    rst = 1'b0;
    e8 = 0;
    e2 = 0;
    push_accept(seg, 1'b0);
    tick(3);
    chk("off_valid_e3", int'(ifa.valid), 0);
    tick(1);
    chk("off_value_e4",   int'(ifa.value),   12);
    chk("off_valid_e4",   int'(ifa.valid),   1);
    chk("off_changed_e4", int'(ifa.changed), 1);
    tick(3);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive side of the 7-segment interface: samples a 7-bit segment pattern (bit0=a … bit6=g) and converts it back into the 4-bit display code.
- Filters glitches and multiplex ghosting with a stability counter, and flags undecodable patterns.
- Counts undecodable patterns in a saturating counter.
- Used as a loopback checker on the display outputs and as a bench monitor.

Parameters:
- STABLE_CYCLES, 4, consecutive enabled samples a pattern must hold before it is accepted; legal range 1..255.
- ERR_W, 8, width of the invalid-pattern counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  sample enable; low freezes all sequential state except the changed pulse
- seg  input  7  segment pattern, bit0=a … bit6=g, 1=lit
- clr_err  input  1  synchronous clear of err_count
- value  output  4  accepted code: 0-9 digits, 10 Correct, 11 Error, 12 off, 13 "?", 15 invalid
- valid  output  1  at least one pattern has been accepted since reset
- invalid  output  1  accepted pattern is undecodable
- changed  output  1  one-cycle pulse when the accepted pattern differs from the previous one
- err_count  output  ERR_W  saturating count of accepted invalid patterns

Behaviour:
- Reset is synchronous, active-high, and overrides everything, including mid-settle.
  - Outputs: value=0, valid=0, invalid=0, changed=0, err_count=0.
  - Internals: seg_q=0, cand=7'h00, cnt=0, accepted pattern=7'h00, state=EMPTY.
- Stage 1 (when en=1): seg_q <= seg.
- Stage 2 (when en=1):
  - If seg_q==cand: cnt <= min(cnt+1, STABLE_CYCLES).
  - Else: cand <= seg_q and cnt <= 1.
  - Call the new cnt value cnt_next.
- Accept event: cnt_next==STABLE_CYCLES, and either state==EMPTY or cand/seg_q differs from the accepted pattern.
- On an accept event, all in the same edge:
  - Store the pattern.
  - Set value to the decoded code, or 15 if undecodable.
  - Set invalid, set valid=1, and set changed=1.
  - Go to state LOCKED.
- State machine:
  - EMPTY: no accept since reset; valid=0.
  - LOCKED: valid=1; left only by reset.
- A re-accept of the pattern already held is not an accept event: no output change and no changed pulse.
- Latency: a pattern P first presented on seg at edge k, held, with en=1, is reflected on the outputs at edge k+STABLE_CYCLES+1.
- Exception after reset: the all-off pattern is accepted at edge STABLE_CYCLES, because cand and seg_q reset to 0.
- Glitch rule: a pattern held fewer than STABLE_CYCLES samples is never accepted.
- changed is high for exactly one cycle after an accept edge. It clears on the next edge regardless of en.
- en=0: seg_q, cand, cnt, outputs and err_count all hold; changed still clears.
- Decode table: the exact patterns below map to their codes; every other pattern is invalid.
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4
  - 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9
  - 0111001→10, 1111001→11, 0000000→12, 1001011→13
- err_count:
  - Increments by 1 on each accept event whose pattern is invalid.
  - Saturates at all-ones; no wrap.
  - clr_err=1 forces 0 and wins over a simultaneous increment.
  - clr_err acts regardless of en.
- Output width rule: value is 4 bits; code 14 is never produced.

Decomposition:
- Package sevenseg_pkg holds:
  - Pattern constants: SEG_0 … SEG_9, SEG_CORRECT, SEG_ERROR, SEG_OFF, SEG_QUERY.
  - Code constants: CODE_CORRECT=10, CODE_ERROR=11, CODE_OFF=12, CODE_QUERY=13, CODE_INVALID=15.
  - The segment bit-order definition.
- The display encoder and this block both use the package.
- One sub-module, sevenseg_pattern_decode: purely combinational, pattern in → {code[3:0], invalid} out.

Test Plan:
- Glitch-free capture: reset, STABLE_CYCLES=4, hold seg=7'b1011011 from edge 1 → value=2, valid=1, invalid=0 at edge 6; changed high exactly one cycle.
- Glitch rejection: locked on 2, drive 7'b1001111 for 2 cycles, then return to 7'b1011011 → value stays 2, changed never pulses, err_count=0.
- Invalid pattern and clear:
  - Hold 7'b1010101 → value=15, invalid=1, err_count=1.
  - Then hold 7'b0110000 → err_count=2.
  - Assert clr_err on the edge of a third invalid accept → err_count=0.
- Enable freeze: present 7'b0111001, drop en after 2 edges for 10 cycles → no output change; restore en → value=10 exactly 3 enabled edges later.
- Saturation: ERR_W=2, alternate four distinct invalid patterns, each held 4 cycles → err_count=3 and stays 3.
- Reset handling:
  - Assert rst mid-settle of 7'b1111111 → all outputs 0 and valid=0 the next edge.
  - With seg=0 after release → value=12, valid=1 at edge 4.
